// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: op_mem bit indices, FSM states,
// bus field offsets and SRAM size encodings. MEM_ALIGN_CHECK_EN widens the WB bundle by one bit.
package mem_stage_pkg;

    localparam int OP_LD_B = 0;
    localparam int OP_LD_H = 1;
    localparam int OP_LD_W = 2;
    localparam int OP_ST_B = 3;
    localparam int OP_ST_H = 4;
    localparam int OP_ST_W = 5;

    // EX -> MEM bundle field offsets
    localparam int EX_BRK       = 219;
    localparam int EX_OP_LSB    = 213;
    localparam int EX_INSTV     = 198;
    localparam int EX_PC_LSB    = 134;
    localparam int EX_INST_LSB  = 102;
    localparam int EX_WIDX_LSB  = 97;
    localparam int EX_WEN       = 96;
    localparam int EX_SDATA_LSB = 64;
    localparam int EX_ADDR_LSB  = 0;
    localparam int INST_ZEXT    = 25;

    // MEM -> WB bundle and bypass offsets
    localparam int WB_WEN      = 32;
    localparam int WB_WIDX_LSB = 33;
    localparam int WB_ALE      = 104;
    localparam int BYP_WEN     = 0;
    localparam int BYP_WIDX_LSB = 1;
    localparam int BYP_DATA_LSB = 6;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

`ifdef MEM_ALIGN_CHECK_EN
    localparam int WB_W_DEF = 105;
`else
    localparam int WB_W_DEF = 104;
`endif

    typedef enum logic [1:0] {S_EMPTY, S_ISSUE, S_WAIT, S_READY} state_e;

    // Only the EX fields MEM actually consumes are kept in the stage register.
    typedef struct packed {
        logic        is_break;
        logic [5:0]  op;
        logic        inst_valid;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  widx;
        logic        wen;
        logic [31:0] sdata;
        logic [31:0] addr;
    } ex_lat_t;

    function automatic logic [1:0] size_of(input logic [5:0] op);
        if (op[OP_LD_B] | op[OP_ST_B])      return SIZE_B;
        else if (op[OP_LD_H] | op[OP_ST_H]) return SIZE_H;
        else                                return SIZE_W;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational load-data aligner: picks the addressed byte/half out of the
// SRAM word and sign- or zero-extends it.
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [5:0]  op_mem_i,
    input  logic        zext_i,
    output logic [31:0] result_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        unused_store_ops;

    assign byte_sel = rdata_i[8*addr_lo_i +: 8];
    assign half_sel = rdata_i[16*addr_lo_i[1] +: 16];
    assign unused_store_ops = ^op_mem_i[OP_ST_W:OP_ST_B];

    always_comb begin
        result_o = rdata_i;
        if (op_mem_i[OP_LD_B])
            result_o = {{24{byte_sel[7] & ~zext_i}}, byte_sel};
        else if (op_mem_i[OP_LD_H])
            result_o = {{16{half_sel[15] & ~zext_i}}, half_sel};
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: accepts the EX bundle, runs one data-SRAM transaction for
// loads/stores, and presents the WB bundle plus bypass. Optional: MEM_ALIGN_CHECK_EN.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int EX_W  = 220,
    parameter int WB_W  = WB_W_DEF,
    parameter int BYP_W = 38
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [EX_W-1:0]  ex_ctrl_bus,
    input  logic             left_valid,
    output logic             left_ready,
    output logic [WB_W-1:0]  mem_ctrl_bus,
    output logic             right_valid,
    input  logic             right_ready,
    output logic [BYP_W-1:0] mem_bypass,
    output logic             mem_load_pending,
    output logic             data_sram_req,
    output logic             data_sram_wr,
    output logic [1:0]       data_sram_size,
    output logic [3:0]       data_sram_wstrb,
    output logic [31:0]      data_sram_addr,
    output logic [31:0]      data_sram_wdata,
    input  logic             data_sram_addr_ok,
    input  logic             data_sram_data_ok,
    input  logic [31:0]      data_sram_rdata
);

    state_e      state_q, state_d;
    ex_lat_t     lat_q, lat_d, lat_in;
    logic [31:0] result_q, result_d;
    logic [31:0] load_data;
    logic        accept, in_mem, in_mis;
    logic        issuing, is_load_q, is_store_q;
    logic        unused_ex_fields;

    assign lat_in = {ex_ctrl_bus[EX_BRK], ex_ctrl_bus[EX_OP_LSB +: 6], ex_ctrl_bus[EX_INSTV],
                     ex_ctrl_bus[EX_PC_LSB +: 32], ex_ctrl_bus[EX_INST_LSB +: 32],
                     ex_ctrl_bus[EX_WIDX_LSB +: 5], ex_ctrl_bus[EX_WEN],
                     ex_ctrl_bus[EX_SDATA_LSB +: 32], ex_ctrl_bus[EX_ADDR_LSB +: 32]};
    assign unused_ex_fields = ^{ex_ctrl_bus[212:199], ex_ctrl_bus[197:166], ex_ctrl_bus[63:32]};

    assign in_mem = |lat_in.op;
`ifdef MEM_ALIGN_CHECK_EN
    logic ale_q, ale_d;
    assign in_mis = ((lat_in.op[OP_LD_H] | lat_in.op[OP_ST_H]) & lat_in.addr[0]) |
                    ((lat_in.op[OP_LD_W] | lat_in.op[OP_ST_W]) & (|lat_in.addr[1:0]));
`else
    assign in_mis = 1'b0;
`endif

    assign left_ready = (state_q == S_EMPTY) | ((state_q == S_READY) & right_ready);
    assign accept     = left_valid & left_ready;
    assign issuing    = (state_q == S_ISSUE);
    assign is_load_q  = |lat_q.op[OP_LD_W:OP_LD_B];
    assign is_store_q = |lat_q.op[OP_ST_W:OP_ST_B];

    mem_load_align u_align (
        .rdata_i   (data_sram_rdata),
        .addr_lo_i (lat_q.addr[1:0]),
        .op_mem_i  (lat_q.op),
        .zext_i    (lat_q.inst[INST_ZEXT]),
        .result_o  (load_data)
    );

    always_comb begin
        state_d  = state_q;
        lat_d    = lat_q;
        result_d = result_q;
`ifdef MEM_ALIGN_CHECK_EN
        ale_d    = ale_q;
`endif
        case (state_q)
            S_ISSUE: if (data_sram_addr_ok) state_d = S_WAIT;
            S_WAIT: begin
                if (data_sram_data_ok) begin
                    state_d = S_READY;
                    if (is_load_q) result_d = load_data;
                end
            end
            S_READY: if (right_ready & ~left_valid) state_d = S_EMPTY;
            default: ;
        endcase
        // A new bundle overrides whatever READY would have done this cycle.
        if (accept) begin
            lat_d    = lat_in;
            result_d = lat_in.addr;
            state_d  = (in_mem & ~in_mis) ? S_ISSUE : S_READY;
            if (in_mis) lat_d.wen = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            ale_d    = in_mis;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_EMPTY;
            lat_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            lat_q    <= lat_d;
            result_q <= result_d;
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) ale_q <= 1'b0;
        else       ale_q <= ale_d;
    end
    assign mem_ctrl_bus = {ale_q, lat_q.is_break, lat_q.inst_valid, lat_q.pc, lat_q.inst,
                           lat_q.widx, lat_q.wen, result_q};
`else
    assign mem_ctrl_bus = {lat_q.is_break, lat_q.inst_valid, lat_q.pc, lat_q.inst,
                           lat_q.widx, lat_q.wen, result_q};
`endif

    assign right_valid      = (state_q == S_READY);
    assign mem_bypass       = right_valid ? {result_q, lat_q.widx, lat_q.wen & lat_q.inst_valid} : '0;
    assign mem_load_pending = ((state_q == S_ISSUE) | (state_q == S_WAIT)) & is_load_q &
                              lat_q.wen & (lat_q.widx != 5'd0);

    assign data_sram_req  = issuing;
    assign data_sram_wr   = issuing & is_store_q;
    assign data_sram_size = issuing ? size_of(lat_q.op) : 2'd0;

    always_comb begin
        data_sram_addr  = '0;
        data_sram_wstrb = '0;
        data_sram_wdata = '0;
        if (issuing) begin
            case (size_of(lat_q.op))
                SIZE_W:  data_sram_addr = {lat_q.addr[31:2], 2'b00};
                SIZE_H:  data_sram_addr = {lat_q.addr[31:1], 1'b0};
                default: data_sram_addr = lat_q.addr;
            endcase
            if (lat_q.op[OP_ST_B]) begin
                data_sram_wstrb = 4'b0001 << lat_q.addr[1:0];
                data_sram_wdata = {4{lat_q.sdata[7:0]}};
            end else if (lat_q.op[OP_ST_H]) begin
                data_sram_wstrb = 4'b0011 << {lat_q.addr[1], 1'b0};
                data_sram_wdata = {2{lat_q.sdata[15:0]}};
            end else if (lat_q.op[OP_ST_W]) begin
                data_sram_wstrb = 4'hF;
                data_sram_wdata = lat_q.sdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: table of single transactions plus
// hand-written stall, backpressure, reset and misalignment sequences.
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int EX_W  = 220;
    localparam int WB_W  = WB_W_DEF;
    localparam int BYP_W = 38;

    logic             clk = 1'b0;
    logic             reset;
    logic [EX_W-1:0]  ex_ctrl_bus;
    logic             left_valid, left_ready;
    logic [WB_W-1:0]  mem_ctrl_bus;
    logic             right_valid, right_ready;
    logic [BYP_W-1:0] mem_bypass;
    logic             mem_load_pending;
    logic             data_sram_req, data_sram_wr;
    logic [1:0]       data_sram_size;
    logic [3:0]       data_sram_wstrb;
    logic [31:0]      data_sram_addr, data_sram_wdata, data_sram_rdata;
    logic             data_sram_addr_ok, data_sram_data_ok;

    int checks = 0;
    int errors = 0;

    mem_stage #(.EX_W(EX_W), .WB_W(WB_W), .BYP_W(BYP_W)) dut (
        .clk(clk), .reset(reset), .ex_ctrl_bus(ex_ctrl_bus),
        .left_valid(left_valid), .left_ready(left_ready),
        .mem_ctrl_bus(mem_ctrl_bus), .right_valid(right_valid), .right_ready(right_ready),
        .mem_bypass(mem_bypass), .mem_load_pending(mem_load_pending),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic        zext;
        logic [4:0]  widx;
        logic        wen;
        logic [31:0] rdata;
        logic [31:0] exp_res;
        logic [31:0] exp_addr;
        logic [1:0]  exp_size;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [EX_W-1:0] mk_bus(input logic [5:0] op, input logic [31:0] addr,
                                               input logic [31:0] sdata, input logic zext,
                                               input logic [4:0] widx, input logic wen);
        logic [EX_W-1:0] b;
        b = '0;
        b[218:213] = op;
        b[212:199] = 14'h2AAA;
        b[198]     = 1'b1;
        b[197:166] = 32'h0BAD_F00D;
        b[165:134] = 32'h0000_8000;
        b[133:102] = 32'h0000_1111;
        b[127]     = zext;
        b[101:97]  = widx;
        b[96]      = wen;
        b[95:64]   = sdata;
        b[63:32]   = 32'hFFFF_FFFF;
        b[31:0]    = addr;
        return b;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic is_mem, is_ld;
        is_mem = |v.op;
        is_ld  = |v.op[2:0];
        ex_ctrl_bus = mk_bus(v.op, v.addr, v.sdata, v.zext, v.widx, v.wen);
        left_valid = 1'b1; right_ready = 1'b1;
        data_sram_addr_ok = 1'b1; data_sram_data_ok = 1'b0;
        #1;
        chk($sformatf("v%0d_left_ready", idx), 64'(left_ready), 64'd1);
        tick();
        left_valid = 1'b0;
        if (is_mem) begin
            chk($sformatf("v%0d_req", idx), 64'(data_sram_req), 64'd1);
            chk($sformatf("v%0d_wr", idx), 64'(data_sram_wr), 64'(|v.op[5:3]));
            chk($sformatf("v%0d_size", idx), 64'(data_sram_size), 64'(v.exp_size));
            chk($sformatf("v%0d_wstrb", idx), 64'(data_sram_wstrb), 64'(v.exp_wstrb));
            chk($sformatf("v%0d_wdata", idx), 64'(data_sram_wdata), 64'(v.exp_wdata));
            chk($sformatf("v%0d_addr", idx), 64'(data_sram_addr), 64'(v.exp_addr));
            chk($sformatf("v%0d_pending", idx), 64'(mem_load_pending),
                64'(is_ld & v.wen & (v.widx != 5'd0)));
            chk($sformatf("v%0d_rv_issue", idx), 64'(right_valid), 64'd0);
            tick();
            data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = v.rdata;
            chk($sformatf("v%0d_req_wait", idx), 64'(data_sram_req), 64'd0);
            chk($sformatf("v%0d_byp_wait", idx), 64'(mem_bypass), 64'd0);
            tick();
            data_sram_data_ok = 1'b0;
        end else begin
            chk($sformatf("v%0d_req_alu", idx), 64'(data_sram_req), 64'd0);
        end
        chk($sformatf("v%0d_rv", idx), 64'(right_valid), 64'd1);
        chk($sformatf("v%0d_wb", idx), 64'(mem_ctrl_bus[37:0]), 64'({v.widx, v.wen, v.exp_res}));
        chk($sformatf("v%0d_byp", idx), 64'(mem_bypass), 64'({v.exp_res, v.widx, v.wen}));
        tick();
        chk($sformatf("v%0d_rv_done", idx), 64'(right_valid), 64'd0);
    endtask

    initial begin
        reset = 1'b1; left_valid = 1'b0; right_ready = 1'b0; ex_ctrl_bus = '0;
        data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = '0;
        //           op     addr        sdata        z  wi wen rdata        result       addr sent    sz  wstrb    wdata
        vecs.push_back('{6'h00, 32'h1234, 32'h0, 1'b0, 5'd5, 1'b1, 32'h0, 32'h1234, 32'h0, 2'd0, 4'h0, 32'h0});
        vecs.push_back('{6'h01, 32'h1003, 32'h0, 1'b0, 5'd2, 1'b1, 32'h80AABBCC, 32'hFFFFFF80, 32'h1003, 2'd0, 4'h0, 32'h0});
        vecs.push_back('{6'h01, 32'h1003, 32'h0, 1'b1, 5'd2, 1'b1, 32'h80AABBCC, 32'h00000080, 32'h1003, 2'd0, 4'h0, 32'h0});
        vecs.push_back('{6'h01, 32'h1001, 32'h0, 1'b0, 5'd0, 1'b1, 32'h80AABBCC, 32'hFFFFFFBB, 32'h1001, 2'd0, 4'h0, 32'h0});
        vecs.push_back('{6'h02, 32'h1002, 32'h0, 1'b0, 5'd9, 1'b1, 32'h80AABBCC, 32'hFFFF80AA, 32'h1002, 2'd1, 4'h0, 32'h0});
        vecs.push_back('{6'h02, 32'h1000, 32'h0, 1'b1, 5'd9, 1'b1, 32'h1234F00D, 32'h0000F00D, 32'h1000, 2'd1, 4'h0, 32'h0});
        vecs.push_back('{6'h04, 32'h1004, 32'h0, 1'b0, 5'd31, 1'b0, 32'hCAFEBABE, 32'hCAFEBABE, 32'h1004, 2'd2, 4'h0, 32'h0});
        vecs.push_back('{6'h10, 32'h2002, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 32'h0, 32'h2002, 32'h2002, 2'd1, 4'b1100, 32'hBEEFBEEF});
        vecs.push_back('{6'h08, 32'h2001, 32'h000000A5, 1'b0, 5'd0, 1'b0, 32'h0, 32'h2001, 32'h2001, 2'd0, 4'b0010, 32'hA5A5A5A5});
        vecs.push_back('{6'h20, 32'h2008, 32'h01020304, 1'b0, 5'd0, 1'b0, 32'h0, 32'h2008, 32'h2008, 2'd2, 4'hF, 32'h01020304});
`ifndef MEM_ALIGN_CHECK_EN
        vecs.push_back('{6'h04, 32'h3001, 32'h0, 1'b0, 5'd4, 1'b1, 32'h11223344, 32'h11223344, 32'h3000, 2'd2, 4'h0, 32'h0});
`endif

        tick(); tick();
        chk("rst_rv", 64'(right_valid), 64'd0);
        chk("rst_req", 64'(data_sram_req), 64'd0);
        chk("rst_wb", 64'(mem_ctrl_bus), 64'd0);
        chk("rst_byp", 64'(mem_bypass), 64'd0);
        chk("rst_pending", 64'(mem_load_pending), 64'd0);
        reset = 1'b0;
        #1;
        chk("rst_left_ready", 64'(left_ready), 64'd1);

        for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

        // addr_ok withheld for 4 cycles, stray data_ok during ISSUE ignored
        ex_ctrl_bus = mk_bus(6'h04, 32'h4000, 32'h0, 1'b0, 5'd7, 1'b1);
        left_valid = 1'b1; right_ready = 1'b1; data_sram_addr_ok = 1'b0;
        tick();
        left_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("stall%0d_req", i), 64'(data_sram_req), 64'd1);
            chk($sformatf("stall%0d_addr", i), 64'(data_sram_addr), 64'h4000);
            chk($sformatf("stall%0d_left_ready", i), 64'(left_ready), 64'd0);
            chk($sformatf("stall%0d_pending", i), 64'(mem_load_pending), 64'd1);
            data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEAD0000;
            tick();
        end
        data_sram_data_ok = 1'b0; data_sram_addr_ok = 1'b1;
        chk("stall_rv", 64'(right_valid), 64'd0);
        tick();
        data_sram_addr_ok = 1'b0;
        chk("stall_req_drop", 64'(data_sram_req), 64'd0);
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h55AA55AA;
        tick();
        data_sram_data_ok = 1'b0;
        chk("stall_rv_ready", 64'(right_valid), 64'd1);
        chk("stall_result", 64'(mem_ctrl_bus[31:0]), 64'h55AA55AA);
        tick();
        chk("stall_req_once", 64'(data_sram_req), 64'd0);

        // WB backpressure, then back-to-back accept when right_ready rises
        ex_ctrl_bus = mk_bus(6'h00, 32'hA1, 32'h0, 1'b0, 5'd3, 1'b1);
        left_valid = 1'b1; right_ready = 1'b0;
        tick();
        ex_ctrl_bus = mk_bus(6'h00, 32'hB2, 32'h0, 1'b0, 5'd4, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp%0d_rv", i), 64'(right_valid), 64'd1);
            chk($sformatf("bp%0d_result", i), 64'(mem_ctrl_bus[37:0]), 64'({5'd3, 1'b1, 32'hA1}));
            chk($sformatf("bp%0d_left_ready", i), 64'(left_ready), 64'd0);
            tick();
        end
        right_ready = 1'b1;
        #1;
        chk("bp_left_ready_rise", 64'(left_ready), 64'd1);
        tick();
        left_valid = 1'b0;
        chk("bp_new_rv", 64'(right_valid), 64'd1);
        chk("bp_new_result", 64'(mem_ctrl_bus[37:0]), 64'({5'd4, 1'b1, 32'hB2}));
        tick();
        chk("bp_empty", 64'(right_valid), 64'd0);

        // Reset during ISSUE drops req next cycle
        ex_ctrl_bus = mk_bus(6'h04, 32'h5000, 32'h0, 1'b0, 5'd8, 1'b1);
        left_valid = 1'b1; data_sram_addr_ok = 1'b0;
        tick();
        left_valid = 1'b0;
        chk("rissue_req", 64'(data_sram_req), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rissue_req_drop", 64'(data_sram_req), 64'd0);
        chk("rissue_pending", 64'(mem_load_pending), 64'd0);

        // Reset during WAIT, late data_ok must be ignored
        left_valid = 1'b1; data_sram_addr_ok = 1'b1;
        tick();
        left_valid = 1'b0;
        tick();
        data_sram_addr_ok = 1'b0;
        chk("rwait_req", 64'(data_sram_req), 64'd0);
        chk("rwait_pending", 64'(mem_load_pending), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h12345678;
        chk("rwait_rv", 64'(right_valid), 64'd0);
        chk("rwait_left_ready", 64'(left_ready), 64'd1);
        tick();
        data_sram_data_ok = 1'b0;
        chk("rwait_rv_after", 64'(right_valid), 64'd0);
        chk("rwait_wb", 64'(mem_ctrl_bus), 64'd0);
        chk("rwait_byp", 64'(mem_bypass), 64'd0);

`ifdef MEM_ALIGN_CHECK_EN
        // Misaligned word load goes straight to READY with ale set
        ex_ctrl_bus = mk_bus(6'h04, 32'h3001, 32'h0, 1'b0, 5'd6, 1'b1);
        left_valid = 1'b1; data_sram_addr_ok = 1'b1;
        tick();
        left_valid = 1'b0;
        chk("ale_req", 64'(data_sram_req), 64'd0);
        chk("ale_rv", 64'(right_valid), 64'd1);
        chk("ale_bit", 64'(mem_ctrl_bus[WB_ALE]), 64'd1);
        chk("ale_wen", 64'(mem_ctrl_bus[WB_WEN]), 64'd0);
        chk("ale_byp_wen", 64'(mem_bypass[BYP_WEN]), 64'd0);
        tick();
        chk("ale_done", 64'(right_valid), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage; consumer end of the EX→MEM valid/ready handshake.
- Latches the EX control bundle, issues load/store transactions on a req/addr_ok/data_ok data-SRAM interface, and aligns and extends load data.
- Presents a registered bundle to WB and drives the mem_bypass forwarding bus back to EX.

Parameters:
- EX_W, 220, width of ex_ctrl_bus.
- WB_W, 104, width of mem_ctrl_bus.
- BYP_W, 38, width of mem_bypass.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- ex_ctrl_bus  in  EX_W  fields:
  - is_break[219], op_mem[218:213], alu_op[212:199], inst_valid[198], Imm[197:166], PC[165:134], Inst[133:102].
  - wreg_index[101:97], wreg_en[96], store data[95:64], reg1[63:32], result/address[31:0].
- left_valid  in  1  EX bundle valid.
- left_ready  out  1  MEM can accept.
- mem_ctrl_bus  out  WB_W  {is_break[103], inst_valid[102], PC[101:70], Inst[69:38], wreg_index[37:33], wreg_en[32], result[31:0]}.
- right_valid  out  1  WB bundle valid.
- right_ready  in  1  WB can accept.
- mem_bypass  out  BYP_W  {data[37:6], wreg_index[5:1], wreg_en[0]}.
- mem_load_pending  out  1  load in flight with a nonzero destination; ID must stall dependents.
- data_sram_req  out  1  request.
- data_sram_wr  out  1  1 = store.
- data_sram_size  out  2  0 = byte, 1 = half, 2 = word.
- data_sram_wstrb  out  4  byte enables.
- data_sram_addr  out  32  address.
- data_sram_wdata  out  32  store data, replicated per lane.
- data_sram_addr_ok  in  1  request accepted.
- data_sram_data_ok  in  1  response/read data valid.
- data_sram_rdata  in  32  read data.

Behaviour:
- op_mem is one-hot: [0] LD_B, [1] LD_H, [2] LD_W, [3] ST_B, [4] ST_H, [5] ST_W. All zero means a non-memory op.
- Inst[25]=1 on LD_B/LD_H selects zero-extension (bu/hu); otherwise sign-extension.
- FSM states: EMPTY, ISSUE, WAIT, READY. Reset → EMPTY, with the stage register and all outputs set to 0.
- left_ready = (EMPTY) | (READY & right_ready). Accept = left_valid & left_ready; the bundle is latched on accept.
- On accept:
  - Memory op → ISSUE.
  - Otherwise → READY, with result = bus[31:0].
- ISSUE:
  - data_sram_req=1. Address, size, wstrb and wdata are driven from the latched bundle and held stable until addr_ok.
  - addr_ok → WAIT.
- WAIT:
  - req=0. data_ok → READY.
  - Loads capture the aligned result: lane = addr[1:0]; byte = rdata[8*lane+:8]; half = rdata[16*addr[1]+:16]; then extend.
  - Stores keep result = address.
- data_ok in ISSUE, or any time in EMPTY/READY, is ignored. This covers stale responses after a reset.
- READY:
  - right_valid=1; the bundle is held while right_ready=0.
  - right_ready & left_valid → accept a new bundle in the same cycle (no bubble).
  - right_ready & !left_valid → EMPTY.
- Store wstrb:
  - ST_B: 1 << addr[1:0], wdata = {4{b}}.
  - ST_H: 4'b0011 << {addr[1],1'b0}, wdata = {2{h}}.
  - ST_W: 4'hF.
  - data_sram_wr=1 for stores only; loads drive wstrb=0.
- Address sent is bus[31:0] with addr[1:0] forced to 0 for word accesses and addr[0] forced to 0 for halves.
- mem_bypass:
  - data = result register.
  - wreg_en = latched wreg_en & (state==READY) & inst_valid.
  - Zero in EMPTY/ISSUE/WAIT.
- mem_load_pending = (ISSUE|WAIT) & load & wreg_en & wreg_index≠0.
- Throughput: a non-memory op takes 1 cycle. A memory op takes at least 3 cycles from accept to right_valid with zero-wait addr_ok and next-cycle data_ok.
- Reset mid-ISSUE/WAIT: immediate EMPTY, req deasserts the following cycle, and the bundle is dropped.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- When defined:
  - A misaligned half (addr[0]) or word (addr[1:0]≠0) goes from accept directly to READY.
  - No SRAM request is issued.
  - wreg_en is cleared.
  - Output ale=1 appended as mem_ctrl_bus bit [104] (WB_W=105).
- When undefined: low address bits are silently masked as above, there is no ale bit, and WB_W=104.

Decomposition:
- Shared package: op_mem bit indices, the FSM state enum, bus field offset constants for ex/wb/bypass, and size encodings.
- One sub-module, mem_load_align (combinational): takes rdata, addr[1:0], op_mem and zero-extend, and returns result[31:0].

Test Plan:
- ALU op, bus[31:0]=0x1234, wreg 5, right_ready=1 → right_valid next cycle; result 0x1234; mem_bypass={0x1234,5,1}; no req.
- LD_B addr 0x1003, rdata 0x80AABBCC, data_ok one cycle after addr_ok → result 0xFFFFFF80. With Inst[25]=1 → 0x00000080. mem_load_pending=1 during ISSUE/WAIT.
- ST_H addr 0x2002, store data 0xDEADBEEF → wstrb 4'b1100, wdata 0xBEEFBEEF, wr=1, size=1, addr 0x2002.
- addr_ok held low 4 cycles → req and addr stable for all 4 cycles; left_ready=0 throughout; one transaction only.
- READY with right_ready=0 for 3 cycles, then 1 with left_valid=1 → bundle held; new bundle accepted the same cycle right_ready rises.
- reset asserted in WAIT, then data_ok arrives → state EMPTY, right_valid stays 0, the response is ignored. Under MEM_ALIGN_CHECK_EN, LD_W at 0x3001 → no req, ale=1.
